stego_decode_ctrl: RTL and testbench

Sequencer for the steganography decode path: walks the cover-image pixel ROM address by address, extracts bit 0 of each pixel, and assembles a 16-bit length header followed by the hidden message bytes. It sits between the pixel ROM (synchronous read port) and the downstream message consumer (valid/ready byte stream). It replaces free-running LSB extraction with a start/done controlled, back-pressurable decode.

---
 rtl/stego_decode_ctrl.sv | 155 +++++++++++++++
 tb/tb_stego_decode_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stego_decode_ctrl.sv
// LSB steganography decode sequencer: reads a pixel ROM bit 0 at a time,
// recovers a length header, then streams the hidden bytes with back-pressure.
module stego_decode_ctrl #(
    parameter int PIXELS   = 41420,
    parameter int ADDR_W   = 16,
    parameter int PIX_W    = 16,
    parameter int LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [LEN_BITS-1:0] msg_len,
    output logic                rom_en,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [PIX_W-1:0]    rom_data,
    output logic [7:0]          byte_data,
    output logic                byte_valid,
    input  logic                byte_ready
);
    typedef enum logic [2:0] {
        IDLE, H_RD, H_CAP, B_RD, B_CAP, B_WAIT, FIN
    } state_t;

    localparam int CW = $clog2(LEN_BITS + 1);
    localparam int AW = LEN_BITS + 4;

    state_t              state, next;
    logic [CW-1:0]       hdr_cnt;
    logic [2:0]          bit_cnt;
    logic [LEN_BITS-1:0] byte_cnt;
    logic [7:0]          asm_q;
    logic                pend;

    logic [LEN_BITS-1:0] len_nxt;
    logic [7:0]          asm_nxt;
    logic [AW-1:0]       need;
    logic                hdr_last, ovf, last_idx, out_free;
    logic                hdr_cap, bit_cap, load;
    logic                unused_bits;

    assign len_nxt  = {msg_len[LEN_BITS-2:0], rom_data[0]};
    assign asm_nxt  = {asm_q[6:0], rom_data[0]};
    assign hdr_last = (hdr_cnt == CW'(LEN_BITS - 1));
    // Wide enough that the pixel budget comparison can never wrap
    assign need     = AW'(LEN_BITS) + (AW'(len_nxt) << 3);
    assign ovf      = (need > AW'(PIXELS));
    assign last_idx = (byte_cnt == msg_len - 1'b1);
    assign out_free = !byte_valid || byte_ready;
    assign unused_bits = ^rom_data[PIX_W-1:1];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:  if (start) next = H_RD;
            H_RD:  next = H_CAP;
            H_CAP: begin
                if (!hdr_last)                     next = H_RD;
                else if (ovf || len_nxt == '0)     next = FIN;
                else                               next = B_RD;
            end
            B_RD:  next = B_CAP;
            B_CAP: begin
                if (bit_cnt != 3'd7)               next = B_RD;
                else if (out_free && !last_idx)    next = B_RD;
                else                               next = B_WAIT;
            end
            B_WAIT: begin
                if (pend) begin
                    if (out_free) next = last_idx ? B_WAIT : B_RD;
                end else if (out_free) begin
                    next = FIN;
                end
            end
            FIN:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        hdr_cap = 1'b0;
        bit_cap = 1'b0;
        load    = 1'b0;
        unique case (state)
            H_CAP:  hdr_cap = 1'b1;
            B_CAP: begin
                bit_cap = 1'b1;
                load    = (bit_cnt == 3'd7) && out_free;
            end
            B_WAIT: load = pend && out_free;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            msg_len    <= '0;
            rom_en     <= 1'b0;
            rom_addr   <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            hdr_cnt    <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            asm_q      <= '0;
            pend       <= 1'b0;
        end else begin
            busy   <= (next != IDLE);
            done   <= (state == FIN);
            rom_en <= (next == H_RD) || (next == B_RD);
            if (state == IDLE) begin
                if (start) begin
                    err      <= 1'b0;
                    msg_len  <= '0;
                    hdr_cnt  <= '0;
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    rom_addr <= '0;
                    pend     <= 1'b0;
                end
            end else if (next == H_RD || next == B_RD) begin
                // Advance only when another pixel will really be read
                rom_addr <= rom_addr + 1'b1;
            end
            if (hdr_cap) begin
                msg_len <= len_nxt;
                hdr_cnt <= hdr_cnt + 1'b1;
                if (hdr_last && ovf) err <= 1'b1;
            end
            if (bit_cap) begin
                asm_q   <= asm_nxt;
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == 3'd7 && !out_free) pend <= 1'b1;
            end
            if (load) begin
                byte_data  <= (state == B_CAP) ? asm_nxt : asm_q;
                byte_valid <= 1'b1;
                byte_cnt   <= byte_cnt + 1'b1;
                pend       <= 1'b0;
            end else if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stego_decode_ctrl.sv
// Bench for stego_decode_ctrl: directed images plus randomized bytes and
// back-pressure, checked against a bit-stream model of the cover image.
module tb_stego_decode_ctrl;
    localparam int PIXELS   = 41420;
    localparam int ADDR_W   = 16;
    localparam int PIX_W    = 16;
    localparam int LEN_BITS = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                busy, done, err, rom_en, byte_valid;
    logic                byte_ready = 1'b1;
    logic [LEN_BITS-1:0] msg_len;
    logic [ADDR_W-1:0]   rom_addr;
    logic [PIX_W-1:0]    rom_data = '0;
    logic [7:0]          byte_data;

    logic [PIX_W-1:0] mem [PIXELS];
    int passed = 0;
    int total  = 0;

    logic [7:0] got[$];
    int hs_cyc[$];
    int vrise[$];
    int done_cyc, done_cnt, max_addr, rd_in_stall, unstable;
    logic busy_at_done;
    logic [LEN_BITS-1:0] mlen32;

    stego_decode_ctrl #(
        .PIXELS(PIXELS), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .LEN_BITS(LEN_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .err(err), .msg_len(msg_len), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total += 1;
        assert (obs === exp) passed += 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_pix(input int i, input logic b, input bit hi);
        mem[i] = {(hi ? 15'h7FFF : 15'($urandom)), b};
    endtask

    task automatic set_hdr(input logic [15:0] h, input bit hi);
        for (int i = 0; i < 16; i++) set_pix(i, h[15-i], hi);
    endtask

    task automatic set_byte(input int k, input logic [7:0] v, input bit hi);
        for (int j = 0; j < 8; j++) set_pix(16 + 8*k + j, v[7-j], hi);
    endtask

    function automatic logic [15:0] ref_len();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v = {v[14:0], mem[i][0]};
        return v;
    endfunction

    function automatic logic [7:0] ref_byte(input int k);
        logic [7:0] v = '0;
        for (int j = 0; j < 8; j++) v = {v[6:0], mem[16 + 8*k + j][0]};
        return v;
    endfunction

    function automatic logic ref_err(input logic [15:0] l);
        return (16 + 8*int'(l)) > PIXELS;
    endfunction

    task automatic run(input int max_cyc, input int stall_from,
                       input int stall_len, input bit rnd,
                       input int kick_at, input int stop_at);
        bit pv, hold;
        logic [7:0] pd;
        pv = 0; hold = 0; pd = '0;
        got.delete(); hs_cyc.delete(); vrise.delete();
        done_cyc = -1; done_cnt = 0; busy_at_done = 1'b1; max_addr = 0;
        rd_in_stall = 0; unstable = 0; mlen32 = 'x;
        @(negedge clk);
        start = 1'b1;
        byte_ready = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= max_cyc; c++) begin
            @(negedge clk);
            start = (c == kick_at);
            if (rom_en && int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            if (rom_en && c > stall_from + 16 && c < stall_from + stall_len)
                rd_in_stall++;
            if (hold && (!byte_valid || byte_data !== pd)) unstable++;
            if (byte_valid && !pv) vrise.push_back(c);
            if (c == 2*LEN_BITS) mlen32 = msg_len;
            if (done) begin
                done_cnt++;
                done_cyc = c;
                busy_at_done = busy;
            end
            byte_ready = rnd ? 1'($urandom_range(0, 1))
                             : !(c >= stall_from && c < stall_from + stall_len);
            if (byte_valid && byte_ready) begin
                got.push_back(byte_data);
                hs_cyc.push_back(c);
            end
            hold = byte_valid && !byte_ready;
            pd = byte_data;
            pv = byte_valid;
            if (done || c == stop_at) break;
        end
        start = 1'b0;
        byte_ready = 1'b1;
        if (stop_at < 0) chk("done_seen", done_cnt, 1);
    endtask

    task automatic chk_bytes(input string tag, input int n_exp);
        if (n_exp >= 0) chk({tag, "_cnt"}, got.size(), n_exp);
        foreach (got[k]) chk($sformatf("%s_b%0d", tag, k), got[k], ref_byte(k));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_len"}, msg_len, 0);
        chk({tag, "_romen"}, rom_en, 0);
        chk({tag, "_addr"}, rom_addr, 0);
        chk({tag, "_bval"}, byte_valid, 0);
        chk({tag, "_bdat"}, byte_data, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        bit hi;
        for (int i = 0; i < PIXELS; i++) mem[i] = PIX_W'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;

        // nominal two-byte message, consumer always ready
        set_hdr(16'h0002, 0);
        set_byte(0, 8'h48, 0);
        set_byte(1, 8'h69, 0);
        run(300, -1000, 0, 0, -1, -1);
        chk("nom_len", msg_len, ref_len());
        chk("nom_len32", mlen32, ref_len());
        chk("nom_err", err, ref_err(ref_len()));
        chk_bytes("nom", 2);
        chk("nom_rises", vrise.size(), 2);
        if (vrise.size() == 2) begin
            chk("nom_rise0", vrise[0], 2*LEN_BITS + 16);
            chk("nom_rise1", vrise[1], 2*LEN_BITS + 32);
        end
        chk("nom_done", done_cyc, 66);
        chk("nom_busy_done", busy_at_done, 0);
        chk("nom_maxaddr", max_addr, LEN_BITS + 8*2 - 1);

        // same image, consumer stalls 40 cycles from first valid
        run(400, 48, 40, 0, -1, -1);
        chk_bytes("stl", 2);
        chk("stl_hold", unstable, 0);
        chk("stl_rom", rd_in_stall, 0);
        chk("stl_hs0", hs_cyc.size() > 0 ? hs_cyc[0] : -1, 48 + 40);
        chk("stl_done", done_cyc,
            hs_cyc.size() > 0 ? hs_cyc[hs_cyc.size()-1] + 2 : -2);

        // empty message
        set_hdr(16'h0000, 0);
        run(100, -1000, 0, 0, -1, -1);
        chk("zero_rises", vrise.size(), 0);
        chk_bytes("zero", 0);
        chk("zero_done", done_cyc, 2*LEN_BITS + 1);
        chk("zero_err", err, 0);
        chk("zero_maxaddr", max_addr, LEN_BITS - 1);

        // header one step past the pixel budget
        set_hdr(16'h1438, 0);
        run(100, -1000, 0, 0, -1, -1);
        chk("ovf_err", err, ref_err(ref_len()));
        chk("ovf_len", msg_len, ref_len());
        chk("ovf_done", done_cyc, 2*LEN_BITS + 1);
        chk_bytes("ovf", 0);
        chk("ovf_maxaddr", max_addr, LEN_BITS - 1);
        repeat (5) @(negedge clk);
        chk("ovf_sticky", err, 1);

        // largest header that still fits, then a long one decoded partially
        set_hdr(16'h1437, 0);
        run(40, -1000, 0, 0, -1, 40);
        chk("fit_err", err, ref_err(ref_len()));
        chk("fit_busy", busy, 1);
        do_reset();
        rst_n = 1'b1;
        set_hdr(16'h1432, 0);
        for (int k = 0; k < 48; k++) set_byte(k, 8'($urandom), 0);
        run(600, -1000, 0, 1, -1, 560);
        chk("big_err", err, ref_err(ref_len()));
        chk("big_len", msg_len, ref_len());
        chk("big_busy", busy, 1);
        chk("big_some", got.size() > 0, 1);
        chk_bytes("big", -1);
        do_reset();
        chk_zero("big_rst");
        rst_n = 1'b1;

        // reset in the middle of the second byte, then a clean re-decode
        set_hdr(16'h0002, 0);
        set_byte(0, 8'h48, 0);
        set_byte(1, 8'h69, 0);
        run(300, -1000, 0, 0, -1, 56);
        do_reset();
        chk_zero("mid_rst");
        rst_n = 1'b1;
        run(300, -1000, 0, 0, -1, -1);
        chk_bytes("redo", 2);
        chk("redo_done", done_cyc, 66);

        // start pulsed while busy, noisy upper pixel bits
        set_hdr(16'h0003, 1);
        for (int k = 0; k < 3; k++) set_byte(k, 8'($urandom), 1);
        run(300, -1000, 0, 0, 40, -1);
        chk("kick_len", msg_len, 3);
        chk_bytes("kick", 3);
        chk("kick_done", done_cyc, 2*LEN_BITS + 16*3 + 2);

        // random messages under random back-pressure
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 6);
            hi = 1'($urandom_range(0, 1));
            set_hdr(16'(n), hi);
            for (int k = 0; k < n; k++) set_byte(k, 8'($urandom), hi);
            run(1000, -1000, 0, 1, (it == 1) ? 60 : -1, -1);
            chk($sformatf("rnd%0d_len", it), msg_len, n);
            chk($sformatf("rnd%0d_err", it), err, 0);
            chk_bytes($sformatf("rnd%0d", it), n);
            chk($sformatf("rnd%0d_hold", it), unstable, 0);
            chk($sformatf("rnd%0d_done", it), done_cyc,
                hs_cyc.size() > 0 ? hs_cyc[hs_cyc.size()-1] + 2 : -2);
            chk($sformatf("rnd%0d_maxaddr", it), max_addr, LEN_BITS + 8*n - 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
